// File: rtl/pexp_pkg.sv
// pexp_pkg: shared types and constants for the port-expander responder.
package pexp_pkg;
    localparam int N_PORTS = 4;
    localparam int NIB_W   = 4;

    typedef enum logic [1:0] {
        READ   = 2'b00,
        WRITE  = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_DRIVE,
        WR_WAIT
    } state_t;

    typedef struct packed {
        bus_op_t    op;
        logic [1:0] addr;
    } cmd_t;

    function automatic logic [NIB_W-1:0] apply_op(bus_op_t op, logic [NIB_W-1:0] old_v, logic [NIB_W-1:0] d);
        return op == OP_OR ? (old_v | d) : op == OP_AND ? (old_v & d) : d;
    endfunction
endpackage

// File: rtl/pexp_responder_if.sv
// pexp_responder_if: MCU-side expander bus (strobe, nibble bus, translator controls).
interface pexp_responder_if;
    import pexp_pkg::*;
    logic             prog_n;
    logic [NIB_W-1:0] p2_i;
    logic [NIB_W-1:0] p2_o;
    logic             p2_oe;
    logic             p2_buf_oe;
    logic             p2_buf_dir;

    modport slave  (input prog_n, p2_i, output p2_o, p2_oe, p2_buf_oe, p2_buf_dir);
    modport master (output prog_n, p2_i, input p2_o, p2_oe, p2_buf_oe, p2_buf_dir);
endinterface

// File: rtl/pexp_sync.sv
// pexp_sync: multi-stage synchroniser whose stages preset to PRESET during reset.
module pexp_sync #(
    parameter int             W      = 1,
    parameter int             STAGES = 2,
    parameter logic [W-1:0]   PRESET = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_stg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) r_stg[k] <= PRESET;
        end else begin
            r_stg[0] <= i_d;
            for (int k = 1; k < STAGES; k++) r_stg[k] <= r_stg[k-1];
        end
    end

    assign o_q = r_stg[STAGES-1];
endmodule

// File: rtl/pexp_responder.sv
// pexp_responder: FPGA-side responder for a 4-port nibble expander driven by an MCU strobe.
// Define PEXP_PROG_FILTER_EN to require two equal synced prog_n samples before an edge is accepted.
module pexp_responder
    import pexp_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [NIB_W-1:0] PORT_RST    = 4'hF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    pexp_responder_if.slave                  bus,
    input  logic [N_PORTS-1:0][NIB_W-1:0]    port_i,
    output logic [N_PORTS-1:0][NIB_W-1:0]    port_o,
    output logic [N_PORTS-1:0]               port_out_mode,
    output logic [N_PORTS-1:0]               wr_stb,
    output logic [N_PORTS-1:0]               rd_stb
);
    logic             w_prog;
    logic [NIB_W-1:0] w_p2;
    logic             w_lvl;
    cmd_t             w_cmd;
    state_t           r_state, w_state_nxt;
    logic             w_start, w_rd_done, w_wr_done;
    logic [1:0]       r_flush_cnt;
    logic             r_armed;
    cmd_t             r_cmd;
    logic [NIB_W-1:0] r_data, r_p2o;
    logic             r_oe, r_dir, r_buf_oe;
    logic [N_PORTS-1:0][NIB_W-1:0] r_port;
    logic [N_PORTS-1:0] r_mode, r_wr, r_rd;

    // Equal depth keeps each p2 sample aligned with the prog_n sample taken on the same edge.
    pexp_sync #(.W(1), .STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_prog (
        .clk(clk), .rst_n(rst_n), .i_d(bus.prog_n), .o_q(w_prog)
    );
    pexp_sync #(.W(NIB_W), .STAGES(SYNC_STAGES), .PRESET(4'hF)) u_sync_p2 (
        .clk(clk), .rst_n(rst_n), .i_d(bus.p2_i), .o_q(w_p2)
    );

`ifdef PEXP_PROG_FILTER_EN
    logic r_prev, r_flt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
            r_flt  <= 1'b1;
        end else begin
            r_prev <= w_prog;
            r_flt  <= w_lvl;
        end
    end
    assign w_lvl = (w_prog == r_prev) ? w_prog : r_flt;
`else
    assign w_lvl = w_prog;
`endif

    assign w_cmd = cmd_t'(w_p2);

    // Preset synchroniser contents are not real samples; arm only on a genuine high seen after flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_flush_cnt <= (r_flush_cnt == 2'(SYNC_STAGES)) ? r_flush_cnt : r_flush_cnt + 2'd1;
            r_armed     <= r_armed | ((r_flush_cnt == 2'(SYNC_STAGES)) & w_prog & w_lvl);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rd_done   = 1'b0;
        w_wr_done   = 1'b0;
        unique case (r_state)
            IDLE: if (r_armed && !w_lvl) begin
                w_start     = 1'b1;
                w_state_nxt = (w_cmd.op == READ) ? RD_DRIVE : WR_WAIT;
            end
            RD_DRIVE: if (w_lvl) begin
                w_rd_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            WR_WAIT: if (w_lvl) begin
                w_wr_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd    <= '0;
            r_data   <= '0;
            r_p2o    <= '0;
            r_oe     <= 1'b0;
            r_dir    <= 1'b0;
            r_buf_oe <= 1'b0;
            r_port   <= {N_PORTS{PORT_RST}};
            r_mode   <= '1;
            r_wr     <= '0;
            r_rd     <= '0;
        end else begin
            r_buf_oe <= 1'b1;
            r_wr     <= '0;
            r_rd     <= '0;
            if (w_start) begin
                r_cmd  <= w_cmd;
                r_data <= w_p2;
            end else if (r_state == WR_WAIT && !w_prog) begin
                r_data <= w_p2;
            end
            if (w_start && w_cmd.op == READ) begin
                r_oe                <= 1'b1;
                r_dir               <= 1'b1;
                r_p2o               <= port_i[w_cmd.addr];
                r_mode[w_cmd.addr]  <= 1'b0;
            end else if (w_rd_done) begin
                r_oe                <= 1'b0;
                r_dir               <= 1'b0;
                r_p2o               <= '0;
                r_rd[r_cmd.addr]    <= 1'b1;
            end else if (r_state == RD_DRIVE) begin
                r_p2o <= port_i[r_cmd.addr];
            end
            if (w_wr_done) begin
                r_port[r_cmd.addr] <= apply_op(r_cmd.op, r_port[r_cmd.addr], r_data);
                r_mode[r_cmd.addr] <= 1'b1;
                r_wr[r_cmd.addr]   <= 1'b1;
            end
        end
    end

    assign bus.p2_o       = r_p2o;
    assign bus.p2_oe      = r_oe;
    assign bus.p2_buf_dir = r_dir;
    assign bus.p2_buf_oe  = r_buf_oe;
    assign port_o         = r_port;
    assign port_out_mode  = r_mode;
    assign wr_stb         = r_wr;
    assign rd_stb         = r_rd;
endmodule

// File: tb/tb_pexp_responder.sv
// tb_pexp_responder: MCU-timed random and directed transactions checked against a port-array model.
`timescale 1ns/1ps
module tb_pexp_responder;
    import pexp_pkg::*;
    localparam int         SS = 2;
    localparam logic [3:0] PR = 4'hF;
`ifdef PEXP_PROG_FILTER_EN
    localparam int LAT = SS + 2;
`else
    localparam int LAT = SS + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    pexp_responder_if bus();
    logic [3:0][3:0] port_i, port_o;
    logic [3:0]      port_out_mode, wr_stb, rd_stb;

    pexp_responder #(.SYNC_STAGES(SS), .PORT_RST(PR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .port_i(port_i), .port_o(port_o),
        .port_out_mode(port_out_mode), .wr_stb(wr_stb), .rd_stb(rd_stb)
    );

    logic [3:0][3:0] m_port;
    logic [3:0]      m_mode;
    int  m_wr[4], m_rd[4], a_wr[4], a_rd[4];
    int  n_chk = 0, n_pass = 0, oe_cnt = 0;
    bit  quiet = 1'b0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp_v, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 4; p++) begin
                a_wr[p] += int'(wr_stb[p]);
                a_rd[p] += int'(rd_stb[p]);
            end
            if (bus.p2_oe) oe_cnt++;
            chk(!(bus.p2_oe && !bus.p2_buf_dir), "oe_without_dir", {bus.p2_oe, bus.p2_buf_dir}, 2'b11);
            chk(!(|wr_stb && |rd_stb) && $countones(wr_stb) <= 1 && $countones(rd_stb) <= 1,
                "strobe_exclusive", {wr_stb, rd_stb}, 0);
            if (quiet) begin
                chk(port_o == m_port, "port_o", port_o, m_port);
                chk(port_out_mode == m_mode, "port_out_mode", port_out_mode, m_mode);
                chk(bus.p2_buf_oe && !bus.p2_oe, "bus_idle", {bus.p2_buf_oe, bus.p2_oe}, 2'b10);
            end
        end
    end

    task automatic chk_counts(input string nm, input int a);
        bit ok = 1'b1;
        for (int p = 0; p < 4; p++) ok &= (a_wr[p] == m_wr[p]) && (a_rd[p] == m_rd[p]);
        chk(ok, nm, 32'(a_wr[a] * 65536 + a_rd[a]), 32'(m_wr[a] * 65536 + m_rd[a]));
    endtask

    task automatic model_reset();
        m_port = {4{PR}};
        m_mode = 4'hF;
    endtask

    // One MCU strobe: 50 ns command setup, 60 ns hold, 700 ns low, data garbled 20 ns after the rise.
    task automatic mcu_txn(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d, output logic [3:0] rd_val);
        int k;
        quiet = 1'b0;
        @(negedge clk);
        bus.p2_i = {op, a};
        #50 bus.prog_n = 1'b0;
        #60 bus.p2_i = (op == 2'b00) ? 4'h0 : d;
        #635;
        rd_val = bus.p2_o;
        if (op == 2'b00) begin
            chk(bus.p2_oe && bus.p2_buf_dir, "rd_drive", {bus.p2_oe, bus.p2_buf_dir}, 2'b11);
            chk(bus.p2_o == port_i[a], "rd_data", bus.p2_o, port_i[a]);
        end else begin
            chk(!bus.p2_oe && !bus.p2_buf_dir, "wr_listen", {bus.p2_oe, bus.p2_buf_dir}, 2'b00);
        end
        #5 bus.prog_n = 1'b1;
        if (op == 2'b00) begin
            k = 0;
            while (bus.p2_oe && k <= LAT) begin
                @(posedge clk);
                #1 k++;
            end
            chk(k <= LAT, "rd_release", k, LAT);
        end else begin
            #20 bus.p2_i = ~d;
        end
        repeat (6) @(negedge clk);
        if (op == 2'b00) begin
            m_mode[a] = 1'b0;
            m_rd[a]++;
        end else begin
            m_port[a] = (op == 2'b01) ? d : (op == 2'b10) ? (m_port[a] | d) : (m_port[a] & d);
            m_mode[a] = 1'b1;
            m_wr[a]++;
        end
        chk_counts("strobe_count", int'(a));
        quiet = 1'b1;
    endtask

    task automatic glitch();
        int oe0 = oe_cnt;
        bus.p2_i = 4'($urandom);
        @(posedge clk);
        #5 bus.prog_n = 1'b0;
        #30 bus.prog_n = 1'b1;
        repeat (8) @(negedge clk);
        chk_counts("glitch_strobes", 0);
        chk(oe_cnt == oe0, "glitch_oe", oe_cnt, oe0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] v, hi, lo;
        logic [7:0] bytes [4];
        int w0, r0;
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int p = 0; p < 4; p++) begin
            m_wr[p] = 0; m_rd[p] = 0; a_wr[p] = 0; a_rd[p] = 0;
        end
        model_reset();
        bus.prog_n = 1'b1;
        bus.p2_i   = 4'hF;
        port_i     = 16'h1234;
        #100;
        chk(!bus.p2_oe && !bus.p2_buf_dir && !bus.p2_buf_oe, "rst_bus", {bus.p2_oe, bus.p2_buf_dir, bus.p2_buf_oe}, 0);
        chk(bus.p2_o == 4'h0, "rst_p2_o", bus.p2_o, 0);
        chk(port_o == 16'hFFFF && port_out_mode == 4'hF, "rst_ports", {port_o, port_out_mode}, 20'hFFFFF);
        chk(wr_stb == 4'h0 && rd_stb == 4'h0, "rst_strobes", {wr_stb, rd_stb}, 0);
        #10 rst_n = 1'b1;
        repeat (SS + 3) @(negedge clk);
        chk(bus.p2_buf_oe, "buf_oe_after_rst", bus.p2_buf_oe, 1);
        quiet = 1'b1;

        w0 = a_wr[3];
        mcu_txn(2'b01, 2'd3, 4'b1111, v);
        mcu_txn(2'b11, 2'd3, 4'b1101, v);
        chk(port_o[3] == 4'b1101 && m_port[3] == 4'b1101, "and_port3", port_o[3], 4'b1101);
        chk(a_wr[3] - w0 == 2, "and_port3_wr", a_wr[3] - w0, 2);

        port_i[2] = 4'hA;
        r0 = a_rd[2];
        mcu_txn(2'b00, 2'd2, 4'h0, v);
        chk(v == 4'hA, "read_port2", v, 4'hA);
        chk(port_out_mode[2] == 1'b0 && a_rd[2] - r0 == 1, "read_port2_side", {port_out_mode[2], 4'(a_rd[2] - r0)}, 5'h01);

        mcu_txn(2'b01, 2'd0, 4'b0001, v);
        mcu_txn(2'b10, 2'd0, 4'b0100, v);
        chk(port_o[0] == 4'b0101 && m_port[0] == 4'b0101, "or_port0", port_o[0], 4'b0101);

        r0 = a_rd[0] + a_rd[1];
        for (int rep = 0; rep < 2; rep++) begin
            for (int b = 0; b < 4; b++) begin
                port_i[0] = bytes[b][7:4];
                port_i[1] = bytes[b][3:0];
                mcu_txn(2'b00, 2'd0, 4'h0, hi);
                mcu_txn(2'b00, 2'd1, 4'h0, lo);
                chk({hi, lo} == bytes[b], "byte_reassembly", {hi, lo}, bytes[b]);
            end
        end
        chk(a_rd[0] + a_rd[1] - r0 == 16, "byte_rd_total", a_rd[0] + a_rd[1] - r0, 16);

        glitch();

        for (int n = 0; n < 40; n++) begin
            port_i = 16'($urandom);
            mcu_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom), v);
            if (n % 10 == 0) glitch();
        end

        mcu_txn(2'b01, 2'd1, 4'h3, v);
        quiet = 1'b0;
        @(negedge clk);
        bus.p2_i = 4'b0101;
        #50 bus.prog_n = 1'b0;
        #60 bus.p2_i = 4'h6;
        #200 rst_n = 1'b0;
        #1;
        chk(!bus.p2_oe && !bus.p2_buf_oe && port_o[1] == PR, "rst_mid_write", {bus.p2_oe, bus.p2_buf_oe, port_o[1]}, {2'b00, PR});
        chk(wr_stb == 4'h0, "rst_mid_write_stb", wr_stb, 0);
        model_reset();
        #25 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        bus.prog_n = 1'b1;
        repeat (8) @(negedge clk);
        chk_counts("rst_write_dropped", 1);
        chk(port_o[1] == PR, "rst_write_port1", port_o[1], PR);
        quiet = 1'b1;

        port_i[3] = 4'h9;
        quiet = 1'b0;
        @(negedge clk);
        bus.p2_i = 4'b0011;
        #50 bus.prog_n = 1'b0;
        #60 bus.p2_i = 4'h0;
        #200;
        chk(bus.p2_oe, "rd_before_rst", bus.p2_oe, 1);
        rst_n = 1'b0;
        #1;
        chk(!bus.p2_oe && !bus.p2_buf_dir, "rst_mid_read", {bus.p2_oe, bus.p2_buf_dir}, 0);
        model_reset();
        #25 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.prog_n = 1'b1;
        repeat (8) @(negedge clk);
        chk_counts("rst_read_dropped", 3);
        quiet = 1'b1;

        mcu_txn(2'b00, 2'd3, 4'h0, v);
        chk(v == 4'h9, "read_after_rst", v, 4'h9);
        glitch();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pexp_responder.md
PEXP_RESPONDER -- requirements
Module: pexp_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchroniser depth for prog_n and p2 inputs (legal 2..3).
REQ-002 Parameter PORT_RST, default 4'hF, reset value of every output port latch.
REQ-003 clk  input  1  system clock; period SHALL be <= 40 ns.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 prog_n  input  1  MCU strobe, asynchronous to clk.
REQ-006 p2_i  input  4  expander bus as seen at the FPGA pins.
REQ-007 p2_o  output  4  expander bus drive value.
REQ-008 p2_oe  output  1  FPGA drives p2 when 1.
REQ-009 p2_buf_oe  output  1  level-translator enable, active high.
REQ-010 p2_buf_dir  output  1  translator direction: 1 = FPGA-to-MCU, 0 = MCU-to-FPGA.
REQ-011 port_i  input  4x4  fabric values returned on READ of ports 0..3.
REQ-012 port_o  output  4x4  latched output values of ports 0..3.
REQ-013 port_out_mode  output  4  1 = port last written, 0 = port last read.
REQ-014 wr_stb  output  4  one-clk pulse when port_o[n] is updated.
REQ-015 rd_stb  output  4  one-clk pulse when a READ of port n completes.

Function
REQ-016 prog_n and p2_i SHALL pass through equal-depth synchronisers so the two stay sample-aligned.
REQ-017 Command nibble = {op[1:0], addr[1:0]}; op READ=00, WRITE=01, OR=10, AND=11.
REQ-018 FSM states: IDLE, RD_DRIVE, WR_WAIT.
REQ-019 IDLE: on the first synced prog_n low sample, capture synced p2 of that same sample as the command.
REQ-020 READ: enter RD_DRIVE; next clk assert p2_buf_dir=1, p2_oe=1, p2_o=port_i[addr], resampled every clk; clear port_out_mode[addr].
REQ-021 RD_DRIVE: on synced prog_n high, drop p2_oe and p2_buf_dir in the same clk, pulse rd_stb[addr], return to IDLE; bus released <= SYNC_STAGES+1 clk after the prog_n rise.
REQ-022 WRITE/OR/AND: enter WR_WAIT with p2_oe=0, p2_buf_dir=0; track synced p2 every clk while prog_n is low.
REQ-023 WR_WAIT: on synced prog_n high, use the p2 sample from the preceding clk (last low sample) as data.
REQ-024 Data application: WRITE sets port_o[addr]=d; OR sets port_o[addr]|=d; AND sets port_o[addr]&=d; all set port_out_mode[addr]=1 and pulse wr_stb[addr]; return to IDLE.
REQ-025 wr_stb SHALL pulse even when the new value equals the old value.
REQ-026 p2_buf_oe=1 in every state except reset; p2_oe SHALL never be 1 while p2_buf_dir=0.
REQ-027 A prog_n low window shorter than one synced sample SHALL be ignored; no strobes.
REQ-028 Only one of wr_stb or rd_stb SHALL be active per transaction.

Reset
REQ-029 While rst_n=0: FSM=IDLE, p2_oe=0, p2_buf_dir=0, p2_buf_oe=0, p2_o=0, port_o=PORT_RST, port_out_mode=4'b1111, strobes=0, synchronisers preset to prog_n high.
REQ-030 Reset asserted mid-transaction SHALL release the bus immediately (asynchronously) and apply no pending write.
REQ-031 After rst_n release, a transaction whose prog_n was already low SHALL be ignored until prog_n is seen high.

Configuration
REQ-032 With PEXP_PROG_FILTER_EN defined, a prog_n edge is accepted only after 2 consecutive equal synced samples; adds 1 clk to REQ-019/021/023 latencies; data = sample preceding the first high sample.
REQ-033 Without PEXP_PROG_FILTER_EN, edges are accepted on the first changed synced sample.

Structure
REQ-034 Package pexp_pkg SHALL hold the bus_op_t enum (READ, WRITE, OP_OR, OP_AND), the state enum, and the port count constant (4).
REQ-035 Sub-module pexp_sync: parameterised-depth, reset-preset synchroniser; instantiated for prog_n (preset 1) and p2_i (preset 4'hF).

Verification
REQ-036 Reset, WRITE port 3 with 4'b1111, then AND port 3 with 4'b1101 -> port_o[3]=4'b1101, two wr_stb[3] pulses.
REQ-037 port_i[2]=4'hA, READ port 2 (MCU timing 50/60/700 ns) -> MCU samples 4'hA, single rd_stb[2], port_out_mode[2]=0, bus released <= 3 clk after the rise.
REQ-038 port_o[0]=4'b0001, OR port 0 with 4'b0100 -> 4'b0101; data changed 20 ns after the prog_n rise SHALL not be captured.
REQ-039 Eight READ cycles of ports 0 and 1 with port_i stepped through DE,AD,BE,EF -> the MCU reassembles each byte; 16 rd_stb pulses total.
REQ-040 rst_n pulsed low during WR_WAIT of WRITE port 1 -> p2_oe=0 immediately, port_o[1]=PORT_RST, no wr_stb.
REQ-041 30 ns prog_n glitch, both with and without PEXP_PROG_FILTER_EN -> no strobes, bus never driven.
